waveform_analyzer: RTL and testbench

//  Receive-side companion to the function generator: consumes an 8-bit sample stream
//  (e.g. a generator output or an ADC) and measures each cycle of the waveform.

---
 rtl/waveform_analyzer.sv | 116 +++++++++++
 tb/tb_waveform_analyzer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_analyzer.sv
// waveform_analyzer: measures each period of an 8-bit sample stream.
// A period runs from one rising midpoint crossing to the next. The crossing
// uses hysteresis. For each completed period the block reports the minimum,
// maximum, peak-to-peak and length in valid samples.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clear           synchronous restart of the measurement; meas_* hold
//   sample_valid    qualifies sample; the logic only advances when high
//   sample[7:0]     unsigned input sample
//   meas_valid      one-cycle pulse, meas_* were updated on the previous edge
//   meas_min/max/pp statistics of the last complete period
//   meas_period     valid samples in the last complete period
//   no_signal       sticky timeout flag, cleared by the next measurement
module waveform_analyzer #(
  parameter int unsigned MID  = 128,
  parameter int unsigned HYST = 8,
  parameter int unsigned PW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample_valid,
  input  logic [7:0]    sample,
  output logic          meas_valid,
  output logic [7:0]    meas_min,
  output logic [7:0]    meas_max,
  output logic [7:0]    meas_pp,
  output logic [PW-1:0] meas_period,
  output logic          no_signal
);

  localparam logic [7:0]    LO_TH   = 8'(MID - HYST);
  localparam logic [7:0]    HI_TH   = 8'(MID + HYST);
  localparam logic [PW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, ARMED, MEAS_HI, MEAS_LO} state_t;

  state_t        state;
  logic [PW-1:0] cnt;
  logic [7:0]    run_min;
  logic [7:0]    run_max;

  // Sample classification; anything between the thresholds is BAND
  logic is_low;
  logic is_high;
  assign is_low  = (sample < LO_TH);
  assign is_high = (sample >= HI_TH);

  // Measurement FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      cnt         <= '0;
      run_min     <= 8'hFF;
      run_max     <= 8'h00;
      meas_valid  <= 1'b0;
      meas_min    <= 8'h00;
      meas_max    <= 8'h00;
      meas_pp     <= 8'h00;
      meas_period <= '0;
      no_signal   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (clear) begin
        state   <= SEARCH;
        cnt     <= '0;
        run_min <= 8'hFF;
        run_max <= 8'h00;
      end else if (sample_valid) begin
        unique case (state)
          SEARCH: begin
            if (is_low) state <= ARMED;
          end
          ARMED: begin
            if (is_high) begin
              state   <= MEAS_HI;
              cnt     <= PW'(1);
              run_min <= sample;
              run_max <= sample;
            end
          end
          MEAS_HI, MEAS_LO: begin
            if (state == MEAS_LO && is_high) begin
              // Edge sample closes the period and seeds the next one
              meas_valid  <= 1'b1;
              meas_min    <= run_min;
              meas_max    <= run_max;
              meas_pp     <= run_max - run_min;
              meas_period <= cnt;
              no_signal   <= 1'b0;
              state       <= MEAS_HI;
              cnt         <= PW'(1);
              run_min     <= sample;
              run_max     <= sample;
            end else if (cnt == CNT_MAX) begin
              // Period too long to count: flag it and re-acquire
              no_signal <= 1'b1;
              state     <= SEARCH;
              cnt       <= '0;
              run_min   <= 8'hFF;
              run_max   <= 8'h00;
            end else begin
              cnt <= cnt + PW'(1);
              if (sample < run_min) run_min <= sample;
              if (sample > run_max) run_max <= sample;
              if (state == MEAS_HI && is_low) state <= MEAS_LO;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_waveform_analyzer.sv
// Self-checking bench for waveform_analyzer: a reference model run at drive
// time pushes expected measurements to a queue; a monitor pops them when
// meas_valid pulses and checks value and cycle of arrival.
module tb_waveform_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        meas_valid;
  logic [7:0]  meas_min;
  logic [7:0]  meas_max;
  logic [7:0]  meas_pp;
  logic [15:0] meas_period;
  logic        no_signal;

  waveform_analyzer #(.MID(128), .HYST(8), .PW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample       (sample),
    .meas_valid   (meas_valid),
    .meas_min     (meas_min),
    .meas_max     (meas_max),
    .meas_pp      (meas_pp),
    .meas_period  (meas_period),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pe     = 0;
  int pulses = 0;

  always @(posedge clk) pe <= pe + 1;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard entry: expected stats plus the posedge that captures the edge
  typedef struct {
    int mn;
    int mx;
    int per;
    int cap;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  typedef enum {M_SEARCH, M_ARMED, M_HI, M_LO} mst_t;
  mst_t m_st   = M_SEARCH;
  int   m_cnt  = 0;
  int   m_min  = 255;
  int   m_max  = 0;
  int   l_min  = 0;
  int   l_max  = 0;
  int   l_per  = 0;

  task automatic model_step(input bit c, input bit v, input int s, input int cap);
    bit lo;
    bit hi;
    exp_t e;
    lo = (s < 120);
    hi = (s >= 136);
    if (c) begin
      m_st = M_SEARCH; m_cnt = 0; m_min = 255; m_max = 0;
    end else if (v) begin
      case (m_st)
        M_SEARCH: if (lo) m_st = M_ARMED;
        M_ARMED:  if (hi) begin m_st = M_HI; m_cnt = 1; m_min = s; m_max = s; end
        default: begin
          if (m_st == M_LO && hi) begin
            e.mn = m_min; e.mx = m_max; e.per = m_cnt; e.cap = cap;
            sbq.push_back(e);
            l_min = m_min; l_max = m_max; l_per = m_cnt;
            m_st = M_HI; m_cnt = 1; m_min = s; m_max = s;
          end else if (m_cnt == 65535) begin
            m_st = M_SEARCH; m_cnt = 0; m_min = 255; m_max = 0;
          end else begin
            m_cnt++;
            if (s < m_min) m_min = s;
            if (s > m_max) m_max = s;
            if (m_st == M_HI && lo) m_st = M_LO;
          end
        end
      endcase
    end
  endtask

  task automatic drive(input bit v, input int s, input bit c);
    @(negedge clk);
    sample_valid = v;
    sample       = 8'(s);
    clear        = c;
    model_step(c, v, s, pe + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic square(input int reps, input bit gaps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 256; i++) begin
        drive(1'b1, (i < 128) ? 0 : 255, 1'b0);
        if (gaps) drive(1'b0, int'($urandom_range(0, 255)), 1'b0);
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; clear = 1'b0;
    m_st = M_SEARCH; m_cnt = 0; m_min = 255; m_max = 0;
    l_min = 0; l_max = 0; l_per = 0;
    @(negedge clk);
    check_val("rst_valid",  int'(meas_valid),  0);
    check_val("rst_min",    int'(meas_min),    0);
    check_val("rst_max",    int'(meas_max),    0);
    check_val("rst_pp",     int'(meas_pp),     0);
    check_val("rst_period", int'(meas_period), 0);
    check_val("rst_nosig",  int'(no_signal),   0);
    rst = 1'b0;
  endtask

  task automatic check_meas(input string tag, input int mn, input int mx, input int per);
    check_val({tag, "_min"},    int'(meas_min),    mn);
    check_val({tag, "_max"},    int'(meas_max),    mx);
    check_val({tag, "_pp"},     int'(meas_pp),     mx - mn);
    check_val({tag, "_period"}, int'(meas_period), per);
  endtask

  // Monitor: every pulse must match the queue head, and no head may go unserved
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (meas_valid || (sbq.size() != 0 && sbq[0].cap <= pe))) begin
      if (meas_valid) pulses++;
      check_val("pulse_present",  int'(meas_valid), 1);
      check_val("pulse_expected", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        check_val("pulse_cycle",  pe, mon_e.cap);
        check_val("pulse_min",    int'(meas_min), mon_e.mn);
        check_val("pulse_max",    int'(meas_max), mon_e.mx);
        check_val("pulse_pp",     int'(meas_pp), mon_e.mx - mon_e.mn);
        check_val("pulse_period", int'(meas_period), mon_e.per);
      end
    end
  end

  int p0;

  initial begin
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample = 8'h00;
    do_reset();

    // 1: square wave, pulses from the second rising edge on
    p0 = pulses;
    square(5, 1'b0);
    idle(3);
    check_val("t1_pulses", pulses - p0, 4);
    check_meas("t1", 0, 255, 256);

    // 2: triangle ramp
    drive(1'b1, 0, 1'b1);
    p0 = pulses;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 512; k++) drive(1'b1, (k < 256) ? k : 511 - k, 1'b0);
    idle(3);
    check_val("t2_pulses", pulses - p0, 3);
    check_meas("t2", 0, 255, 512);

    // 3: band samples never complete a period; FSM must still be in MEAS_HI
    drive(1'b1, 0, 1'b1);
    p0 = pulses;
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 200, 1'b0);
    for (int i = 0; i < 1000; i++) drive(1'b1, (i % 2 == 0) ? 125 : 131, 1'b0);
    idle(3);
    check_val("t3_no_pulse", pulses - p0, 0);
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 200, 1'b0);
    idle(3);
    check_val("t3_pulses", pulses - p0, 1);
    check_meas("t3", 0, 200, 1002);

    // 4: valid toggling every cycle, latency checked by the monitor
    drive(1'b1, 0, 1'b1);
    p0 = pulses;
    square(3, 1'b1);
    idle(3);
    check_val("t4_pulses", pulses - p0, 2);
    check_meas("t4", 0, 255, 256);

    // 5: timeout after 2^16-1 counted samples
    drive(1'b1, 0, 1'b1);
    p0 = pulses;
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 8'h90, 1'b0);
    for (int i = 0; i < 65535; i++) drive(1'b1, 8'h90, 1'b0);
    idle(3);
    check_val("t5_no_pulse", pulses - p0, 0);
    check_val("t5_nosig_set", int'(no_signal), 1);
    check_meas("t5_hold", l_min, l_max, l_per);
    check_meas("t5_hold_const", 0, 255, 256);
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 8'h90, 1'b0);
    square(1, 1'b0);
    idle(3);
    check_val("t5_pulses", pulses - p0, 1);
    check_val("t5_nosig_clr", int'(no_signal), 0);
    check_meas("t5", 0, 8'h90, 129);

    // 6a: clear at sample 60 discards the partial period
    drive(1'b1, 0, 1'b1);
    square(2, 1'b0);
    idle(3);
    p0 = pulses;
    for (int i = 0; i < 60; i++) drive(1'b1, 0, 1'b0);
    drive(1'b1, 0, 1'b1);
    for (int i = 0; i < 67; i++) drive(1'b1, 0, 1'b0);
    for (int i = 0; i < 128; i++) drive(1'b1, 255, 1'b0);
    idle(3);
    check_val("t6c_no_pulse", pulses - p0, 0);
    square(1, 1'b0);
    idle(3);
    check_val("t6c_pulses", pulses - p0, 1);
    check_meas("t6c", 0, 255, 256);

    // 6b: reset at sample 60 behaves the same, with outputs zeroed
    p0 = pulses;
    for (int i = 0; i < 60; i++) drive(1'b1, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 67; i++) drive(1'b1, 0, 1'b0);
    for (int i = 0; i < 128; i++) drive(1'b1, 255, 1'b0);
    idle(3);
    check_val("t6r_no_pulse", pulses - p0, 0);
    square(1, 1'b0);
    idle(3);
    check_val("t6r_pulses", pulses - p0, 1);
    check_meas("t6r", 0, 255, 256);

    check_val("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
